// File: rtl/viterbi_pkg.sv
// Shared types, constants and reference symbol function for the
// convolutional encoder and Viterbi decoder.
package viterbi_pkg;

  localparam int K = 4;
  localparam int NSTATES = 8;
  localparam logic [3:0] G0_DEF = 4'b1111;
  localparam logic [3:0] G1_DEF = 4'b1101;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  function automatic sym_t conv_sym(
    input logic [K-1:0] v,
    input logic [K-1:0] g0,
    input logic [K-1:0] g1
  );
    return {^(v & g0), ^(v & g1)};
  endfunction

endpackage

// File: rtl/conv_step.sv
// One trellis step: (sr, u) -> channel symbol and next shift register.
module conv_step
  import viterbi_pkg::*;
#(
  parameter logic [3:0] G0 = G0_DEF,
  parameter logic [3:0] G1 = G1_DEF
) (
  input  logic [2:0] sr,
  input  logic       u,
  output logic [1:0] sym,
  output logic [2:0] next_sr
);

  assign sym     = conv_sym({u, sr}, G0, G1);
  assign next_sr = {u, sr[2:1]};

endmodule

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=4 convolutional encoder with framing, zero tail and a
// registered, backpressured symbol output.
module conv_encoder_framer #(
  parameter int         FRAME_LEN = 256,
  parameter int         K         = 4,
  parameter logic [3:0] G0        = 4'b1111,
  parameter logic [3:0] G1        = 4'b1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] sym,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       sym_first,
  output logic       sym_last,
  output logic       busy
);

  import viterbi_pkg::*;

  localparam int CW = $clog2(FRAME_LEN + 1);

  enc_state_t    state, state_n;
  logic [2:0]    sr, sr_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [1:0]    tail_cnt, tail_cnt_n;
  logic [1:0]    step_sym;
  logic          first_n, last_n;
  logic          slot_free, accept, step, u;

  assign slot_free = !sym_valid || sym_ready;
  assign in_ready  = rst && enable && slot_free
                  && (state == IDLE || state == DATA);
  assign accept    = in_ready && in_valid;
  assign step      = accept
                  || (enable && slot_free && state == TAIL);
  assign u         = (state == TAIL) ? 1'b0 : in_bit;
  assign busy      = (state != IDLE) || sym_valid;

  conv_step #(
    .G0(G0),
    .G1(G1)
  ) u_step (
    .sr     (sr),
    .u      (u),
    .sym    (step_sym),
    .next_sr(sr_n)
  );

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    tail_cnt_n = tail_cnt;
    first_n    = 1'b0;
    last_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          first_n    = 1'b1;
          bit_cnt_n  = CW'(1);
          tail_cnt_n = 2'd0;
          state_n    = (FRAME_LEN == 1) ? TAIL : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == CW'(FRAME_LEN - 1)) begin
            state_n    = TAIL;
            tail_cnt_n = 2'd0;
          end
        end
      end
      TAIL: begin
        if (step) begin
          tail_cnt_n = tail_cnt + 2'd1;
          if (tail_cnt == 2'(K - 2)) begin
            last_n    = 1'b1;
            bit_cnt_n = '0;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= 3'b000;
      bit_cnt   <= '0;
      tail_cnt  <= 2'd0;
      sym       <= 2'b00;
      sym_valid <= 1'b0;
      sym_first <= 1'b0;
      sym_last  <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      sr        <= 3'b000;
      bit_cnt   <= '0;
      tail_cnt  <= 2'd0;
      sym       <= 2'b00;
      sym_valid <= 1'b0;
      sym_first <= 1'b0;
      sym_last  <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      tail_cnt <= tail_cnt_n;
      if (step) begin
        sr        <= sr_n;
        sym       <= step_sym;
        sym_valid <= 1'b1;
        sym_first <= first_n;
        sym_last  <= last_n;
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
        sym_first <= 1'b0;
        sym_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer (FRAME_LEN=4 and FRAME_LEN=1).
module tb_conv_encoder_framer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;

  logic iv4 = 1'b0, ib4 = 1'b0, sr4 = 1'b1;
  logic ir4, sv4, sf4, sl4, bz4;
  logic [1:0] sy4;
  logic iv1 = 1'b0, ib1 = 1'b0, sr1 = 1'b1;
  logic ir1, sv1, sf1, sl1, bz1;
  logic [1:0] sy1;

  always #5 clk = ~clk;

  conv_encoder_framer #(.FRAME_LEN(4)) u4 (
    .clk(clk), .rst(rst), .enable(enable),
    .in_bit(ib4), .in_valid(iv4), .in_ready(ir4),
    .sym(sy4), .sym_valid(sv4), .sym_ready(sr4),
    .sym_first(sf4), .sym_last(sl4), .busy(bz4)
  );

  conv_encoder_framer #(.FRAME_LEN(1)) u1 (
    .clk(clk), .rst(rst), .enable(enable),
    .in_bit(ib1), .in_valid(iv1), .in_ready(ir1),
    .sym(sy1), .sym_valid(sv1), .sym_ready(sr1),
    .sym_first(sf1), .sym_last(sl1), .busy(bz1)
  );

  int vectors = 0;
  int miscompares = 0;

  bit sel = 1'b0;
  bit feed[$];
  logic [1:0] sym_log[$];
  bit vld_log[$], rdy_log[$], busy_log[$], first_log[$];
  logic [1:0] hs_sym[$];
  bit hs_first[$], hs_last[$];
  int hs_cyc[$];
  int ncyc;

  logic [1:0] exp_a [7] = '{2'b11, 2'b11, 2'b01, 2'b11,
                            2'b01, 2'b01, 2'b11};
  logic [1:0] exp_one [4] = '{2'b11, 2'b11, 2'b10, 2'b11};

  function automatic void clr();
    feed.delete(); sym_log.delete(); vld_log.delete();
    rdy_log.delete(); busy_log.delete(); first_log.delete();
    hs_sym.delete(); hs_first.delete(); hs_last.delete();
    hs_cyc.delete(); ncyc = 0;
  endfunction

  // Independent reference: c0 = u^s2^s1^s0, c1 = u^s2^s0.
  function automatic void model(input bit b[$], output logic [1:0] o[$]);
    bit [2:0] s = 3'b000;
    o.delete();
    for (int i = 0; i < b.size() + 3; i++) begin
      bit uu = (i < b.size()) ? b[i] : 1'b0;
      o.push_back({uu ^ s[2] ^ s[1] ^ s[0], uu ^ s[2] ^ s[0]});
      s = {uu, s[2:1]};
    end
  endfunction

  task automatic cyc(input bit pres, input bit r, input bit en);
    bit v, rd, vl, rr;
    @(negedge clk);
    enable = en;
    v = pres && (feed.size() > 0);
    iv4 = !sel && v;
    iv1 = sel && v;
    ib4 = (feed.size() > 0) ? feed[0] : 1'b0;
    ib1 = ib4;
    sr4 = sel ? 1'b1 : r;
    sr1 = sel ? r : 1'b1;
    #1;
    rd = sel ? ir1 : ir4;
    vl = sel ? sv1 : sv4;
    rr = sel ? sr1 : sr4;
    sym_log.push_back(sel ? sy1 : sy4);
    vld_log.push_back(vl);
    rdy_log.push_back(rd);
    busy_log.push_back(sel ? bz1 : bz4);
    first_log.push_back(sel ? sf1 : sf4);
    if (v && rd) void'(feed.pop_front());
    if (vl && rr) begin
      hs_sym.push_back(sel ? sy1 : sy4);
      hs_first.push_back(sel ? sf1 : sf4);
      hs_last.push_back(sel ? sl1 : sl4);
      hs_cyc.push_back(ncyc);
    end
    ncyc++;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({sy4, sv4, sf4, sl4, ir4, bz4} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset4 got %b want 0000000", {sy4, sv4, sf4, sl4, ir4, bz4});
    end
    vectors++;
    if ({sy1, sv1, sf1, sl1, ir1, bz1} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset1 got %b want 0000000", {sy1, sv1, sf1, sl1, ir1, bz1});
    end
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    clr();
    feed = '{1, 0, 1, 1};
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b1);
    vectors++;
    if (hs_sym.size() != 7) begin
      miscompares++;
      $display("FAIL basic_count got %0d want 7", hs_sym.size());
    end
    for (int i = 0; i < 7 && i < hs_sym.size(); i++) begin
      vectors++;
      if (hs_sym[i] !== exp_a[i] || hs_cyc[i] != i + 1
          || hs_first[i] !== (i == 0) || hs_last[i] !== (i == 6)) begin
        miscompares++;
        $display("FAIL basic_sym%0d got %b@%0d f%b l%b want %b@%0d",
                 i, hs_sym[i], hs_cyc[i], hs_first[i], hs_last[i],
                 exp_a[i], i + 1);
      end
    end
    for (int c = 4; c <= 6; c++) begin
      vectors++;
      if (rdy_log[c] !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_tail_ready c%0d got %b want 0", c, rdy_log[c]);
      end
    end
  endtask

  task automatic test_stall();
    sel = 1'b0;
    clr();
    feed = '{1, 0, 1, 1};
    for (int i = 0; i < 14; i++)
      cyc(1'b1, !(i >= 3 && i <= 5), 1'b1);
    vectors++;
    if (hs_sym.size() != 7) begin
      miscompares++;
      $display("FAIL stall_count got %0d want 7", hs_sym.size());
    end
    for (int i = 0; i < 7 && i < hs_sym.size(); i++) begin
      vectors++;
      if (hs_sym[i] !== exp_a[i] || hs_first[i] !== (i == 0)
          || hs_last[i] !== (i == 6)) begin
        miscompares++;
        $display("FAIL stall_sym%0d got %b want %b", i, hs_sym[i], exp_a[i]);
      end
    end
    for (int c = 3; c <= 5; c++) begin
      vectors++;
      if (sym_log[c] !== 2'b01 || vld_log[c] !== 1'b1
          || rdy_log[c] !== 1'b0 || first_log[c] !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold c%0d got %b v%b r%b want 01 v1 r0",
                 c, sym_log[c], vld_log[c], rdy_log[c]);
      end
    end
  endtask

  task automatic test_gaps();
    bit pat [8] = '{1, 0, 1, 0, 0, 1, 1, 1};
    sel = 1'b0;
    clr();
    feed = '{1, 0, 1, 1};
    for (int i = 0; i < 14; i++) cyc(i < 8 ? pat[i] : 1'b1, 1'b1, 1'b1);
    vectors++;
    if (hs_sym.size() != 7) begin
      miscompares++;
      $display("FAIL gaps_count got %0d want 7", hs_sym.size());
    end
    for (int i = 0; i < 7 && i < hs_sym.size(); i++) begin
      vectors++;
      if (hs_sym[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL gaps_sym%0d got %b want %b", i, hs_sym[i], exp_a[i]);
      end
    end
    vectors++;
    if ({vld_log[2], vld_log[4], vld_log[5]} !== 3'b000) begin
      miscompares++;
      $display("FAIL gaps_bubble got %b want 000",
               {vld_log[2], vld_log[4], vld_log[5]});
    end
  endtask

  task automatic test_frame_len1();
    sel = 1'b1;
    clr();
    feed = '{1};
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1);
    vectors++;
    if (hs_sym.size() != 4) begin
      miscompares++;
      $display("FAIL len1_count got %0d want 4", hs_sym.size());
    end
    for (int i = 0; i < 4 && i < hs_sym.size(); i++) begin
      vectors++;
      if (hs_sym[i] !== exp_one[i] || hs_first[i] !== (i == 0)
          || hs_last[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL len1_sym%0d got %b f%b l%b want %b",
                 i, hs_sym[i], hs_first[i], hs_last[i], exp_one[i]);
      end
    end
    if (hs_cyc.size() == 4) begin
      vectors++;
      if (busy_log[hs_cyc[3]] !== 1'b1 || busy_log[hs_cyc[3] + 1] !== 1'b0) begin
        miscompares++;
        $display("FAIL len1_busy got %b%b want 10",
                 busy_log[hs_cyc[3]], busy_log[hs_cyc[3] + 1]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_enable_drop();
    sel = 1'b0;
    clr();
    feed = '{1, 0};
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    vectors++;
    if (sv4 !== 1'b0 || u4.state !== viterbi_pkg::IDLE
        || u4.sr !== 3'b000 || bz4 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort got v%b st%0d sr%b want v0 st0 sr000",
               sv4, u4.state, u4.sr);
    end
    clr();
    feed = '{1, 0, 1, 1};
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b1);
    vectors++;
    if (hs_sym.size() != 7) begin
      miscompares++;
      $display("FAIL abort_count got %0d want 7", hs_sym.size());
    end
    for (int i = 0; i < 7 && i < hs_sym.size(); i++) begin
      vectors++;
      if (hs_sym[i] !== exp_a[i] || hs_cyc[i] != i + 1
          || hs_first[i] !== (i == 0) || hs_last[i] !== (i == 6)) begin
        miscompares++;
        $display("FAIL abort_sym%0d got %b want %b", i, hs_sym[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    clr();
    feed = '{1, 0, 1, 1};
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1);
    vectors++;
    if (u4.state !== viterbi_pkg::TAIL || sv4 !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre got st%0d v%b want st2 v1", u4.state, sv4);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({sy4, sv4, sf4, sl4, ir4, bz4} !== 7'b0) begin
      miscompares++;
      $display("FAIL arst got %b want 0000000", {sy4, sv4, sf4, sl4, ir4, bz4});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit bits[$];
    logic [1:0] e1[$], e2[$];
    sel = 1'b0;
    clr();
    bits = '{1, 0, 1, 1};
    model(bits, e1);
    bits = '{0, 1, 1, 0};
    model(bits, e2);
    e1 = {e1, e2};
    feed = '{1, 0, 1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1);
    vectors++;
    if (hs_sym.size() != 14) begin
      miscompares++;
      $display("FAIL b2b_count got %0d want 14", hs_sym.size());
    end
    for (int i = 0; i < 14 && i < hs_sym.size(); i++) begin
      vectors++;
      if (hs_sym[i] !== e1[i] || hs_cyc[i] != i + 1
          || hs_first[i] !== (i % 7 == 0) || hs_last[i] !== (i % 7 == 6)) begin
        miscompares++;
        $display("FAIL b2b_sym%0d got %b@%0d f%b l%b want %b@%0d",
                 i, hs_sym[i], hs_cyc[i], hs_first[i], hs_last[i],
                 e1[i], i + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_frame_len1();
    test_enable_drop();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
